// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue.
// Takes fetch addresses from the PC register, issues one instruction-memory
// request at a time, and buffers up to two {pc, npc, instr} entries for
// decode. A flush discards everything already buffered, and also discards any
// response still owed by memory. Decode outputs come straight from the
// head-entry registers.
module instr_fetch_queue (
    input  logic        clk,
    input  logic        reset,

    // PC register side
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    output logic        pc_ready,

    // Instruction memory side
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,

    // Redirect
    input  logic        flush,

    // Decode side
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_npc,
    input  logic        id_ready
);

    typedef enum logic [1:0] {
        S_IDLE,   // no request in flight; may accept a new pc
        S_REQ,    // request presented, waiting for imem_gnt
        S_RESP,   // granted, waiting for imem_rvalid; data is kept
        S_DROP    // granted, waiting for imem_rvalid; data is discarded
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // Address of the request in flight. It is also the pc of the next entry
    // that gets pushed.
    logic [31:0] r_addr;

    // Set when a flush arrives while the request is still ungranted, so that
    // the eventual response is thrown away.
    logic        r_flushed;

    // Two-entry queue. Entry 0 is always the head, and entry 1 sits behind it.
    logic [1:0]  r_count;
    logic [31:0] r_pc0;
    logic [31:0] r_pc1;
    logic [31:0] r_npc0;
    logic [31:0] r_npc1;
    logic [31:0] r_instr0;
    logic [31:0] r_instr1;

    logic        w_pc_ready;
    logic        w_req;
    logic        w_push;
    logic        w_pop;
    logic        w_accept;
    logic [31:0] w_npc;

    // Next-state and handshake decode for the fetch FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case statement. A
        // path that left one unassigned would infer a latch.
        w_next_state = r_state;
        w_pc_ready   = 1'b0;
        w_req        = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Nothing is outstanding in IDLE, so the occupancy alone
                // decides whether a new fetch still fits.
                w_pc_ready = !flush && (r_count < 2'd2);
                if (pc_valid && w_pc_ready) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                w_req = 1'b1;
                if (imem_gnt) begin
                    w_next_state = (r_flushed || flush) ? S_DROP : S_RESP;
                end
            end
            S_RESP: begin
                if (flush) begin
                    // A response that arrives together with the flush is
                    // simply dropped. Otherwise it is still owed, so it must
                    // be absorbed in DROP.
                    w_next_state = imem_rvalid ? S_IDLE : S_DROP;
                end else if (imem_rvalid) begin
                    w_push       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_accept = pc_valid && w_pc_ready;
    assign w_pop    = (r_count != 2'd0) && id_ready;
    assign w_npc    = r_addr + 32'd4;

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so that every
        // flop samples values from before the edge, whatever the order in
        // which the blocks are evaluated.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request address capture and memory of a flush seen while ungranted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= 32'd0;
            r_flushed <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= pc_in & 32'hFFFF_FFFC;
            end
            r_flushed <= (r_state == S_REQ) && !imem_gnt && (r_flushed || flush);
        end
    end

    // Queue storage: push at the tail, pop from the head, and clear on flush.
    always_ff @(posedge clk) begin
        // NOTE: the data registers are cleared along with the count, because
        // the decode outputs read them directly and must show zero after
        // reset or flush.
        if (reset || flush) begin
            r_count  <= 2'd0;
            r_pc0    <= 32'd0;
            r_pc1    <= 32'd0;
            r_npc0   <= 32'd0;
            r_npc1   <= 32'd0;
            r_instr0 <= 32'd0;
            r_instr1 <= 32'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_pc0    <= r_addr;
                        r_npc0   <= w_npc;
                        r_instr0 <= imem_rdata;
                    end else begin
                        r_pc1    <= r_addr;
                        r_npc1   <= w_npc;
                        r_instr1 <= imem_rdata;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_pc0    <= r_pc1;
                    r_npc0   <= r_npc1;
                    r_instr0 <= r_instr1;
                    r_pc1    <= 32'd0;
                    r_npc1   <= 32'd0;
                    r_instr1 <= 32'd0;
                    r_count  <= r_count - 2'd1;
                end
                2'b11: begin
                    // The occupancy does not change. The new entry goes in
                    // directly behind whatever remains after the pop.
                    if (r_count == 2'd1) begin
                        r_pc0    <= r_addr;
                        r_npc0   <= w_npc;
                        r_instr0 <= imem_rdata;
                    end else begin
                        r_pc0    <= r_pc1;
                        r_npc0   <= r_npc1;
                        r_instr0 <= r_instr1;
                        r_pc1    <= r_addr;
                        r_npc1   <= w_npc;
                        r_instr1 <= imem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Reset also masks pc_ready, so the PC register cannot load while the
    // queue is being cleared.
    assign pc_ready  = w_pc_ready && !reset;
    assign imem_req  = w_req;
    assign imem_addr = r_addr;

    assign id_valid  = (r_count != 2'd0);
    assign id_pc     = r_pc0;
    assign id_npc    = r_npc0;
    assign id_instr  = r_instr0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed testbench for instr_fetch_queue. It covers reset, a single fetch
// with its latency, backpressure, simultaneous push and pop, flush in REQ and
// in RESP, and reset in the middle of a fetch.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_npc;
    logic        id_ready;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_npc      (id_npc),
        .id_ready    (id_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full fetch with zero-wait memory: accept, then grant, then data.
    // Returns just after the edge where the entry is pushed.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
        int n;
        pc_in    = a;
        pc_valid = 1'b1;
        #1;
        n = 0;
        while (!pc_ready && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("fetch_accept", {31'd0, pc_ready}, 32'd1);
        tick();
        pc_valid = 1'b0;
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        tick();
        imem_rvalid = 1'b0;
    endtask

    // Check the head entry, then pop it.
    task automatic pop_expect(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        check({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
        check({tag, "_pc"}, id_pc, exp_pc);
        check({tag, "_npc"}, id_npc, exp_pc + 32'd4);
        check({tag, "_instr"}, id_instr, exp_instr);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        pc_in       = 32'd0;
        pc_valid    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        flush       = 1'b0;
        id_ready    = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_pc_ready", {31'd0, pc_ready}, 32'd0);
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_id_valid", {31'd0, id_valid}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_id_instr", id_instr, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_npc", id_npc, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_pc_ready", {31'd0, pc_ready}, 32'd1);

        // ---------------- single fetch with its latency ----------------
        pc_in    = 32'h0040_0000;
        pc_valid = 1'b1;
        #1;
        check("sf_pc_ready_N", {31'd0, pc_ready}, 32'd1);
        tick();                                   // cycle N+1
        pc_valid = 1'b0;
        check("sf_req_N1", {31'd0, imem_req}, 32'd1);
        check("sf_addr_N1", imem_addr, 32'h0040_0000);
        check("sf_pc_ready_N1", {31'd0, pc_ready}, 32'd0);
        imem_gnt = 1'b1;
        tick();                                   // cycle N+2
        imem_gnt = 1'b0;
        check("sf_req_N2", {31'd0, imem_req}, 32'd0);
        check("sf_id_valid_N2", {31'd0, id_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h8C02_0004;
        tick();                                   // cycle N+3
        imem_rvalid = 1'b0;
        check("sf_id_valid_N3", {31'd0, id_valid}, 32'd1);
        check("sf_id_pc", id_pc, 32'h0040_0000);
        check("sf_id_npc", id_npc, 32'h0040_0004);
        check("sf_id_instr", id_instr, 32'h8C02_0004);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("sf_empty_after_pop", {31'd0, id_valid}, 32'd0);

        // ---------------- backpressure ----------------
        do_fetch(32'h0000_0000, 32'hA000_0000);
        do_fetch(32'h0000_0004, 32'hA000_0004);
        pc_in    = 32'h0000_0008;
        pc_valid = 1'b1;
        #1;
        check("bp_pc_ready_full", {31'd0, pc_ready}, 32'd0);
        tick();
        tick();
        check("bp_no_req_full", {31'd0, imem_req}, 32'd0);
        check("bp_head_pc", id_pc, 32'h0000_0000);
        check("bp_head_instr", id_instr, 32'hA000_0000);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        #1;
        check("bp_pc_ready_after_pop", {31'd0, pc_ready}, 32'd1);
        do_fetch(32'h0000_0008, 32'hA000_0008);
        pop_expect("bp_second", 32'h0000_0004, 32'hA000_0004);
        pop_expect("bp_third", 32'h0000_0008, 32'hA000_0008);
        check("bp_empty", {31'd0, id_valid}, 32'd0);

        // ---------------- simultaneous push and pop at occupancy 1 ----------------
        do_fetch(32'h0000_0020, 32'hB000_0020);
        pc_in    = 32'h0000_0024;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hB000_0024;
        id_ready    = 1'b1;
        check("pp_head_before", id_pc, 32'h0000_0020);
        tick();
        imem_rvalid = 1'b0;
        id_ready    = 1'b0;
        pop_expect("pp_after", 32'h0000_0024, 32'hB000_0024);
        check("pp_occupancy_was_1", {31'd0, id_valid}, 32'd0);

        // ---------------- flush in RESP ----------------
        do_fetch(32'h0000_0030, 32'hC000_0030);
        pc_in    = 32'h0000_0010;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        imem_gnt = 1'b1;
        tick();                                   // now in RESP
        imem_gnt = 1'b0;
        flush    = 1'b1;
        #1;
        check("fr_pc_ready_flush", {31'd0, pc_ready}, 32'd0);
        tick();
        flush = 1'b0;
        check("fr_cleared", {31'd0, id_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("fr_dropped_valid", {31'd0, id_valid}, 32'd0);
        check("fr_dropped_instr", id_instr, 32'd0);
        #1;
        check("fr_idle_again", {31'd0, pc_ready}, 32'd1);
        do_fetch(32'h0000_0100, 32'h1234_5678);
        pop_expect("fr_next", 32'h0000_0100, 32'h1234_5678);

        // ---------------- flush in RESP together with rvalid ----------------
        pc_in    = 32'h0000_0200;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        flush       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        flush       = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        check("frv_id_valid", {31'd0, id_valid}, 32'd0);
        check("frv_back_to_idle", {31'd0, pc_ready}, 32'd1);

        // ---------------- flush in REQ, grant held off 3 cycles ----------------
        pc_in    = 32'h0000_0047;                 // low bits must be masked
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        check("fq_req_c1", {31'd0, imem_req}, 32'd1);
        check("fq_addr_c1", imem_addr, 32'h0000_0044);
        tick();
        flush = 1'b1;
        check("fq_req_c2", {31'd0, imem_req}, 32'd1);
        check("fq_addr_c2", imem_addr, 32'h0000_0044);
        tick();
        flush = 1'b0;
        check("fq_req_c3", {31'd0, imem_req}, 32'd1);
        check("fq_addr_c3", imem_addr, 32'h0000_0044);
        tick();
        imem_gnt = 1'b1;
        check("fq_req_gnt", {31'd0, imem_req}, 32'd1);
        tick();                                   // now in DROP
        imem_gnt = 1'b0;
        check("fq_req_after_gnt", {31'd0, imem_req}, 32'd0);
        check("fq_pc_ready_drop", {31'd0, pc_ready}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        tick();
        imem_rvalid = 1'b0;
        check("fq_dropped", {31'd0, id_valid}, 32'd0);
        #1;
        check("fq_idle_again", {31'd0, pc_ready}, 32'd1);

        // ---------------- reset in RESP, stray rvalid afterwards ----------------
        pc_in    = 32'h0000_0060;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        imem_gnt = 1'b1;
        tick();                                   // now in RESP
        imem_gnt = 1'b0;
        reset    = 1'b1;
        tick();
        reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_1111;
        #1;
        check("rr_req_after_reset", {31'd0, imem_req}, 32'd0);
        check("rr_addr_after_reset", imem_addr, 32'd0);
        tick();
        imem_rvalid = 1'b0;
        check("rr_id_valid", {31'd0, id_valid}, 32'd0);
        check("rr_id_instr", id_instr, 32'd0);
        check("rr_req", {31'd0, imem_req}, 32'd0);
        do_fetch(32'h0000_0070, 32'h7070_7070);
        pop_expect("rr_recover", 32'h0000_0070, 32'h7070_7070);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset (ports clk, reset); no other clock or asynchronous input is permitted.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pc_in  input  32  fetch address from the PC register.
REQ-005 pc_valid  input  1  pc_in is valid this cycle.
REQ-006 pc_ready  output  1  queue accepts pc_in this cycle; drives the PC register load enable.
REQ-007 imem_req  output  1  instruction-memory request.
REQ-008 imem_addr  output  32  request address, word-aligned.
REQ-009 imem_gnt  input  1  memory accepted the request this cycle.
REQ-010 imem_rvalid  input  1  imem_rdata is valid this cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 flush  input  1  branch/jump redirect; discard all fetched and in-flight instructions.
REQ-013 id_valid  output  1  head entry is valid for decode.
REQ-014 id_instr  output  32  head instruction.
REQ-015 id_pc  output  32  head instruction address.
REQ-016 id_npc  output  32  id_pc + 4, modulo 2^32.
REQ-017 id_ready  input  1  decode consumes the head entry this cycle.

Function
REQ-018 Queue depth SHALL be 2 entries of {pc, instr}; at most one memory request SHALL be outstanding at a time.
REQ-019 FSM states SHALL be IDLE, REQ, RESP and DROP.
REQ-020 pc_ready SHALL be 1 only in IDLE with flush=0 and (occupancy + outstanding) < 2; pc_ready SHALL NOT depend combinationally on id_ready.
REQ-021 On pc_valid && pc_ready, pc_in SHALL be latched into imem_addr with bits [1:0] forced to 0, and the FSM SHALL go IDLE->REQ.
REQ-022 In REQ, imem_req SHALL be 1 with imem_addr held stable until imem_gnt; on imem_gnt the FSM SHALL go to RESP, or to DROP if a flush occurred while in REQ.
REQ-023 In RESP, imem_rvalid SHALL write {imem_addr, imem_rdata} to the queue tail and return the FSM to IDLE; imem_rdata SHALL be ignored when imem_rvalid=0.
REQ-024 In DROP, the next imem_rvalid SHALL be discarded and the FSM SHALL return to IDLE.
REQ-025 Flush handling SHALL be:
- all queue entries cleared next cycle, so id_valid=0;
- in RESP the FSM goes to DROP, unless imem_rvalid is also high that cycle, in which case the data is dropped and the FSM goes to IDLE;
- in REQ, imem_req stays asserted until imem_gnt and the FSM then goes to DROP.
REQ-026 id_valid, id_instr, id_pc and id_npc SHALL be driven from queue registers; a pop SHALL occur on id_valid && id_ready.
REQ-027 A push and a pop in the same cycle SHALL be legal at any occupancy; occupancy SHALL be unchanged and order SHALL be preserved.
REQ-028 id_ready when id_valid=0 SHALL have no effect; an overflow SHALL be impossible by REQ-020.
REQ-029 Minimum latency SHALL be: pc accepted in cycle N, imem_req in N+1, imem_rvalid in N+2 at earliest, id_valid in N+3.
REQ-030 Back-to-back throughput SHALL be one instruction every 3 cycles with zero-wait memory; this is accepted.

Reset
REQ-031 On reset=1 at a clock edge:
- the FSM SHALL go to IDLE and the queue SHALL empty;
- imem_req, id_valid and pc_ready SHALL be 0, and imem_addr, id_instr, id_pc and id_npc SHALL be 0;
- pc_ready SHALL become 1 in the cycle after reset deasserts, per REQ-020.
REQ-032 Reset mid-operation SHALL abandon any outstanding request; a late imem_rvalid arriving after reset SHALL be ignored while in IDLE.
REQ-033 Reset SHALL take priority over flush and over all handshakes.

Verification
REQ-034 Single fetch: reset, then pc_in=0x00400000 with pc_valid=1, and imem_gnt/imem_rvalid each one cycle later with rdata=0x8C020004 -> id_valid in cycle N+3 with id_pc=0x00400000, id_npc=0x00400004, id_instr=0x8C020004.
REQ-035 Backpressure: id_ready=0 with fetches at 0x0, 0x4 and 0x8 -> pc_ready drops after 2 accepts and 0x8 is not accepted; one pop with id_ready=1 -> 0x8 is then accepted, and the output order is 0x0, 0x4, 0x8.
REQ-036 Flush in RESP: flush asserted while awaiting rdata for 0x10, with rvalid of 0xDEADBEEF one cycle later -> the queue is empty and 0xDEADBEEF never appears; the next fetch 0x100 is delivered correctly.
REQ-037 Flush in REQ: imem_gnt held low for 3 cycles with flush in cycle 2 -> imem_req and imem_addr are stable until gnt, and the response is dropped.
REQ-038 Simultaneous push and pop at occupancy 1 -> occupancy stays 1, with FIFO order preserved.
REQ-039 Reset while in RESP, followed by a stray imem_rvalid -> id_valid stays 0 and imem_req=0.
